truth_table_sequencer: RTL and testbench

//  Sequences an exhaustive truth-table sweep over a shared N_IN-bit input bus that

---
 rtl/truth_table_sequencer_if.sv | 14 +
 rtl/truth_table_sequencer.sv | 133 +++++++++++++
 tb/tb_truth_table_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sequencer_if.sv
// Row delivery channel from the sequencer to a logger: valid/ready plus the row payload.
interface truth_table_sequencer_if #(
  parameter int N_IN     = 3,
  parameter int NUM_IMPL = 3
);
  logic                row_valid;
  logic                row_ready;
  logic [N_IN-1:0]     row_vec;
  logic [NUM_IMPL-1:0] row_y;
  logic [NUM_IMPL-1:0] row_mismatch;

  modport master (output row_valid, row_vec, row_y, row_mismatch, input row_ready);
  modport slave  (input row_valid, row_vec, row_y, row_mismatch, output row_ready);
endinterface

// File: rtl/truth_table_sequencer.sv
// Exhaustive truth-table sweep: drives every input vector to NUM_IMPL implementations,
// waits SETTLE cycles, samples them, flags disagreement with implementation 0 and
// hands one row per vector to a logger.
module truth_table_sequencer #(
  parameter int N_IN     = 3,
  parameter int NUM_IMPL = 3,
  parameter int SETTLE   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [N_IN-1:0]     abc_out,
  input  logic [NUM_IMPL-1:0] y_in,
  truth_table_sequencer_if.master row_if,
  output logic                busy,
  output logic                done,
  output logic [N_IN:0]       err_count,
  output logic                first_err_valid,
  output logic [N_IN-1:0]     first_err_vec
);
  // Settle counter must hold SETTLE; keep at least one bit when SETTLE is 0.
  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN:0]   EC_ONE   = (N_IN + 1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_EMIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     abc_q, abc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [NUM_IMPL-1:0] y_q, y_d;
  logic [NUM_IMPL-1:0] mis_q, mis_d;
  logic [N_IN:0]       ec_q, ec_d;
  logic                fe_q, fe_d;
  logic [N_IN-1:0]     fev_q, fev_d;
  logic [NUM_IMPL-1:0] mis;

  // Bit 0 compares the reference with itself and is therefore always 0.
  assign mis = y_in ^ {NUM_IMPL{y_in[0]}};

  // Next-state and datapath updates for the sweep FSM.
  always_comb begin
    state_d = state_q;
    abc_d   = abc_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    y_d     = y_q;
    mis_d   = mis_q;
    ec_d    = ec_q;
    fe_d    = fe_q;
    fev_d   = fev_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          abc_d   = '0;
          cnt_d   = CNT_LOAD;
          ec_d    = '0;
          fe_d    = 1'b0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == '0) state_d = S_SAMPLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      S_SAMPLE: begin
        vec_d   = abc_q;
        y_d     = y_in;
        mis_d   = mis;
        state_d = S_EMIT;
        if (|mis) begin
          ec_d = ec_q + EC_ONE;
          if (!fe_q) begin
            fe_d  = 1'b1;
            fev_d = abc_q;
          end
        end
      end
      S_EMIT: begin
        if (row_if.row_ready) begin
          if (abc_q == VEC_LAST) begin
            state_d = S_DONE;
          end else begin
            abc_d   = abc_q + VEC_ONE;
            cnt_d   = CNT_LOAD;
            state_d = S_DRIVE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any sweep immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      abc_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      y_q     <= '0;
      mis_q   <= '0;
      ec_q    <= '0;
      fe_q    <= 1'b0;
      fev_q   <= '0;
    end else begin
      state_q <= state_d;
      abc_q   <= abc_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      y_q     <= y_d;
      mis_q   <= mis_d;
      ec_q    <= ec_d;
      fe_q    <= fe_d;
      fev_q   <= fev_d;
    end
  end

  assign abc_out             = abc_q;
  assign row_if.row_valid    = (state_q == S_EMIT);
  assign row_if.row_vec      = vec_q;
  assign row_if.row_y        = y_q;
  assign row_if.row_mismatch = mis_q;
  assign busy                = (state_q == S_DRIVE) || (state_q == S_SAMPLE) || (state_q == S_EMIT);
  assign done                = (state_q == S_DONE);
  assign err_count           = ec_q;
  assign first_err_valid     = fe_q;
  assign first_err_vec       = fev_q;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: two instances (SETTLE=1 and SETTLE=0) driven by
// behavioural implementation models, rows checked against a scoreboard queue.
module tb_truth_table_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] vec; logic [2:0] y; logic [2:0] mis; } row_t;
  typedef struct {
    int dut; int mode; int stall_vec; int stall_len; int poke_vec;
    int exp_err; int exp_fe; int exp_fev;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic       start_s[2];
  logic       ready_s[2];
  int         mode_s[2];
  logic [2:0] y_s[2];
  logic [2:0] abc_s[2], rvec_s[2], ry_s[2], rmis_s[2], fev_s[2];
  logic [3:0] ec_s[2];
  logic       rv_s[2], busy_s[2], done_s[2], fe_s[2];
  row_t       qa[$], qb[$];

  truth_table_sequencer_if #(.N_IN(3), .NUM_IMPL(3)) if_a ();
  truth_table_sequencer_if #(.N_IN(3), .NUM_IMPL(3)) if_b ();

  truth_table_sequencer #(.N_IN(3), .NUM_IMPL(3), .SETTLE(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_s[0]), .abc_out(abc_s[0]), .y_in(y_s[0]),
    .row_if(if_a), .busy(busy_s[0]), .done(done_s[0]), .err_count(ec_s[0]),
    .first_err_valid(fe_s[0]), .first_err_vec(fev_s[0]));

  truth_table_sequencer #(.N_IN(3), .NUM_IMPL(3), .SETTLE(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_s[1]), .abc_out(abc_s[1]), .y_in(y_s[1]),
    .row_if(if_b), .busy(busy_s[1]), .done(done_s[1]), .err_count(ec_s[1]),
    .first_err_valid(fe_s[1]), .first_err_vec(fev_s[1]));

  assign if_a.row_ready = ready_s[0];
  assign if_b.row_ready = ready_s[1];
  assign rv_s[0] = if_a.row_valid;    assign rv_s[1] = if_b.row_valid;
  assign rvec_s[0] = if_a.row_vec;    assign rvec_s[1] = if_b.row_vec;
  assign ry_s[0] = if_a.row_y;        assign ry_s[1] = if_b.row_y;
  assign rmis_s[0] = if_a.row_mismatch; assign rmis_s[1] = if_b.row_mismatch;

  // Implementations under test: majority function, with faults selected by mode.
  function automatic logic [2:0] model_y(input int mode, input logic [2:0] v);
    logic f;
    f = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    case (mode)
      0:       return 3'b000;
      1:       return 3'b111;
      2:       return {f ^ (v == 3'd5), f, f};
      default: return {f, ~f, f};
    endcase
  endfunction

  function automatic logic [2:0] exp_mis(input int mode, input logic [2:0] v);
    if (mode == 2 && v == 3'd5) return 3'b100;
    if (mode == 3)              return 3'b010;
    return 3'b000;
  endfunction

  assign y_s[0] = model_y(mode_s[0], abc_s[0]);
  assign y_s[1] = model_y(mode_s[1], abc_s[1]);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic mon(input int d, input row_t r);
    chk(d == 0 ? "a_row_vec" : "b_row_vec", 32'(rvec_s[d]), 32'(r.vec));
    chk(d == 0 ? "a_row_y" : "b_row_y", 32'(ry_s[d]), 32'(r.y));
    chk(d == 0 ? "a_row_mis" : "b_row_mis", 32'(rmis_s[d]), 32'(r.mis));
  endtask

  // Scoreboard pop on every accepted row.
  always @(negedge clk) begin
    if (rv_s[0] && ready_s[0]) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_row_extra: unexpected row vec=%0d", rvec_s[0]);
      end else mon(0, qa.pop_front());
    end
    if (rv_s[1] && ready_s[1]) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_row_extra: unexpected row vec=%0d", rvec_s[1]);
      end else mon(1, qb.pop_front());
    end
  end

  task automatic push_rows(input int d, input int mode);
    row_t r;
    for (int v = 0; v < 8; v++) begin
      r.vec = 3'(v); r.y = model_y(mode, 3'(v)); r.mis = exp_mis(mode, 3'(v));
      if (d == 0) qa.push_back(r); else qb.push_back(r);
    end
  endtask

  task automatic run(input vec_t t);
    int cyc, stalled, exp_cyc;
    bit poked;
    mode_s[t.dut] = t.mode;
    push_rows(t.dut, t.mode);
    start_s[t.dut] = 1'b1;
    @(posedge clk); #1;
    start_s[t.dut] = 1'b0;
    chk("start_done_clr", 32'(done_s[t.dut]), 0);
    chk("start_busy", 32'(busy_s[t.dut]), 1);
    chk("start_vec0", 32'(abc_s[t.dut]), 0);
    chk("start_err_clr", 32'(ec_s[t.dut]), 0);
    cyc = 0; stalled = 0; poked = 0;
    while (!done_s[t.dut] && cyc < 300) begin
      if (rv_s[t.dut] && rvec_s[t.dut] == 3'(t.stall_vec) && stalled < t.stall_len) begin
        if (stalled > 0) begin
          chk("stall_valid", 32'(rv_s[t.dut]), 1);
          chk("stall_abc", 32'(abc_s[t.dut]), 32'(t.stall_vec));
          chk("stall_row_y", 32'(ry_s[t.dut]), 32'(model_y(t.mode, 3'(t.stall_vec))));
        end
        ready_s[t.dut] = 1'b0;
        stalled++;
      end else ready_s[t.dut] = 1'b1;
      if (!poked && t.poke_vec >= 0 && busy_s[t.dut] && !rv_s[t.dut] &&
          abc_s[t.dut] == 3'(t.poke_vec)) begin
        start_s[t.dut] = 1'b1; poked = 1;
      end else start_s[t.dut] = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    ready_s[t.dut] = 1'b1;
    start_s[t.dut] = 1'b0;
    exp_cyc = 8 * (t.dut == 0 ? 4 : 3) + t.stall_len;
    chk("sweep_cycles", 32'(cyc), 32'(exp_cyc));
    chk("done", 32'(done_s[t.dut]), 1);
    chk("busy_end", 32'(busy_s[t.dut]), 0);
    chk("valid_end", 32'(rv_s[t.dut]), 0);
    chk("err_count", 32'(ec_s[t.dut]), 32'(t.exp_err));
    chk("first_err_valid", 32'(fe_s[t.dut]), 32'(t.exp_fe));
    if (t.exp_fe != 0) chk("first_err_vec", 32'(fev_s[t.dut]), 32'(t.exp_fev));
    chk("rows_left", 32'(t.dut == 0 ? qa.size() : qb.size()), 0);
  endtask

  task automatic chk_reset_outputs(input int d);
    chk("rst_abc", 32'(abc_s[d]), 0);
    chk("rst_valid", 32'(rv_s[d]), 0);
    chk("rst_busy", 32'(busy_s[d]), 0);
    chk("rst_done", 32'(done_s[d]), 0);
    chk("rst_err", 32'(ec_s[d]), 0);
    chk("rst_fe", 32'(fe_s[d]), 0);
    chk("rst_fev", 32'(fev_s[d]), 0);
    chk("rst_row", 32'({rvec_s[d], ry_s[d], rmis_s[d]}), 0);
  endtask

  vec_t tbl[7];

  initial begin
    //          dut mode svec slen poke err fe fev
    tbl[0] = '{0, 0, -1, 0, -1, 0, 0, 0};
    tbl[1] = '{0, 1, -1, 0, -1, 0, 0, 0};
    tbl[2] = '{0, 2, -1, 0, -1, 1, 1, 5};
    tbl[3] = '{0, 0,  3, 4, -1, 0, 0, 0};
    tbl[4] = '{0, 0, -1, 0,  2, 0, 0, 0};
    tbl[5] = '{1, 3, -1, 0, -1, 8, 1, 0};
    tbl[6] = '{1, 2, -1, 0, -1, 1, 1, 5};
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; ready_s[d] = 1'b1; mode_s[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run(tbl[i]);

    // Reset in the middle of a mismatching sweep, then restart from vector 0.
    mode_s[0] = 3;
    push_rows(0, 3);
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    for (int i = 0; i < 100 && abc_s[0] != 3'd4; i++) begin
      @(posedge clk); #1;
    end
    chk("midsweep_vec4", 32'(abc_s[0]), 4);
    chk("midsweep_err", 32'(ec_s[0]), 4);
    reset = 1'b1;
    #1;
    chk_reset_outputs(0);
    qa.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run('{0, 2, -1, 0, -1, 1, 1, 5});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
